// File: rtl/vga_line_scanout_if.sv
// Framebuffer read bus between the line scan-out stage and the memory arbiter.
// Requests are held until granted; read responses return in request order.
interface vga_line_scanout_if;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/vga_line_scanout.sv
// Fetches a 320x240 RGB565 framebuffer line by line into ping-pong buffers and
// scans it out 2x-scaled behind the VGA timing generator, syncs delayed to match.
module vga_line_scanout #(
    parameter logic [16:0] FB_BASE         = 17'h00000,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [15:0] UNDERRUN_COLOR  = 16'hF81F
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [9:0]                pixel_x,
    input  logic [9:0]                pixel_y,
    input  logic                      display_en,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      frame_start,
    vga_line_scanout_if.master        mem,
    output logic [15:0]               rgb,
    output logic                      out_hsync,
    output logic                      out_vsync,
    output logic                      out_de,
    output logic                      underrun
);

    localparam logic [8:0] LINE_PIXELS = 9'd320;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} fetch_state_e;

    fetch_state_e state_q;
    logic [8:0]   issued_q, received_q, issued_d, received_d, outstanding;
    logic [16:0]  base_q, trig_base;
    logic         tgt_q;
    logic [8:0]   fill_q [2];

    logic         de_prev_q, vs_prev_q;
    logic [9:0]   y_prev_q;
    logic         vs_fall, de_fall, trigger, drop_trigger, grant, resp;
    logic [7:0]   trig_line;

    logic         rd_buf, rd_hit;
    logic [8:0]   rd_idx;
    logic         s1_de_q, s1_hs_q, s1_vs_q, s1_hit_q, s1_buf_q;
    logic [15:0]  rd0_q, rd1_q;
    logic [15:0]  rgb_q;
    logic         out_de_q, out_hs_q, out_vs_q;
    logic         underrun_q, underrun_d;

    logic [15:0]  line_buf0 [320];
    logic [15:0]  line_buf1 [320];

    // Horizontal scaling discards the x LSB.
    logic         unused_x_lsb;
    assign unused_x_lsb = pixel_x[0];

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        vs_fall      = vs_prev_q & ~vsync_in;
        de_fall      = de_prev_q & ~display_en & ~y_prev_q[0] & (y_prev_q < 10'd478);
        trigger      = vs_fall | de_fall;
        trig_line    = 8'd0;
        if (!vs_fall) begin
            trig_line = 8'(y_prev_q[9:1]) + 8'd1;
        end
        trig_base    = FB_BASE + 17'(trig_line) * 17'd320;
        drop_trigger = trigger && (state_q != IDLE);

        outstanding  = issued_q - received_q;
        mem.mem_req  = (state_q == ISSUE) && (issued_q < LINE_PIXELS)
                       && (outstanding < 9'(MAX_OUTSTANDING));
        mem.mem_addr = base_q + 17'(issued_q);
        grant        = mem.mem_req & mem.mem_gnt;
        resp         = mem.mem_rvalid && (state_q != IDLE) && (received_q < LINE_PIXELS);
        issued_d     = issued_q + {8'd0, grant};
        received_d   = received_q + {8'd0, resp};

        rd_buf       = pixel_y[1];
        rd_idx       = pixel_x[9:1];
        rd_hit       = rd_idx < fill_q[rd_buf];

        underrun_d   = underrun_q;
        if (frame_start) begin
            underrun_d = 1'b0;
        end
        if ((display_en && !rd_hit) || drop_trigger) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            issued_q   <= '0;
            received_q <= '0;
            base_q     <= '0;
            tgt_q      <= 1'b0;
            fill_q[0]  <= '0;
            fill_q[1]  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_q           <= ISSUE;
                        issued_q          <= '0;
                        received_q        <= '0;
                        base_q            <= trig_base;
                        tgt_q             <= trig_line[0];
                        fill_q[trig_line[0]] <= '0;
                    end
                end
                ISSUE: begin
                    issued_q   <= issued_d;
                    received_q <= received_d;
                    if (issued_d == LINE_PIXELS) state_q <= DRAIN;
                end
                DRAIN: begin
                    received_q <= received_d;
                    if (received_d == LINE_PIXELS) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (resp) fill_q[tgt_q] <= fill_q[tgt_q] + 9'd1;
        end
    end

    // NOTE: line buffers are plain storage with no reset; fill counts alone decide validity.
    always_ff @(posedge clk) begin
        if (resp && !tgt_q) line_buf0[received_q] <= mem.mem_rdata;
        if (resp &&  tgt_q) line_buf1[received_q] <= mem.mem_rdata;
        rd0_q <= line_buf0[rd_idx];
        rd1_q <= line_buf1[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b1;
            y_prev_q   <= '0;
            s1_de_q    <= 1'b0;
            s1_hs_q    <= 1'b1;
            s1_vs_q    <= 1'b1;
            s1_hit_q   <= 1'b0;
            s1_buf_q   <= 1'b0;
            rgb_q      <= '0;
            out_de_q   <= 1'b0;
            out_hs_q   <= 1'b1;
            out_vs_q   <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            de_prev_q  <= display_en;
            vs_prev_q  <= vsync_in;
            y_prev_q   <= pixel_y;
            s1_de_q    <= display_en;
            s1_hs_q    <= hsync_in;
            s1_vs_q    <= vsync_in;
            s1_hit_q   <= rd_hit;
            s1_buf_q   <= rd_buf;
            out_de_q   <= s1_de_q;
            out_hs_q   <= s1_hs_q;
            out_vs_q   <= s1_vs_q;
            underrun_q <= underrun_d;
            if (!s1_de_q)      rgb_q <= '0;
            else if (!s1_hit_q) rgb_q <= UNDERRUN_COLOR;
            else               rgb_q <= s1_buf_q ? rd1_q : rd0_q;
        end
    end

    assign rgb       = rgb_q;
    assign out_de    = out_de_q;
    assign out_hsync = out_hs_q;
    assign out_vsync = out_vs_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_vga_line_scanout.sv
// Directed bench for vga_line_scanout: fetch stream, 2x scan-out, outstanding
// limit, underrun and overlap, against a latency-configurable memory model.
module tb_vga_line_scanout;

    localparam logic [16:0] TB_BASE = 17'h01000;
    localparam int          TB_MAX  = 4;
    localparam logic [15:0] UC      = 16'hF81F;

    typedef struct {
        logic [16:0] addr;
        int          due;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pixel_x, pixel_y;
    logic        display_en, hsync_in, vsync_in, frame_start;
    logic [15:0] rgb;
    logic        out_hsync, out_vsync, out_de, underrun;

    vga_line_scanout_if mem_if ();

    vga_line_scanout #(
        .FB_BASE         (TB_BASE),
        .MAX_OUTSTANDING (TB_MAX),
        .UNDERRUN_COLOR  (UC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .display_en  (display_en),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .frame_start (frame_start),
        .mem         (mem_if.master),
        .rgb         (rgb),
        .out_hsync   (out_hsync),
        .out_vsync   (out_vsync),
        .out_de      (out_de),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          chk_en   = 1'b0;
    bit          gnt_en   = 1'b1;
    int          lat      = 2;
    int          edge_no  = 0;
    rsp_t        rsp_q [$];
    int          n_grant, n_resp, bad_seq, max_pend, lim_viol;
    logic [16:0] first_addr, last_addr;
    logic [15:0] p_rgb [2];
    logic        p_de [2], p_hs [2], p_vs [2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] pix(input int x, input int y);
        logic [16:0] a;
        a = TB_BASE + 17'((y / 2) * 320 + x / 2);
        return a[15:0];
    endfunction

    task automatic clear_log();
        n_grant  = 0;
        n_resp   = 0;
        bad_seq  = 0;
        max_pend = 0;
        lim_viol = 0;
    endtask

    // Memory model: decides grant and response for the upcoming rising edge.
    task automatic mem_step();
        int pend;
        pend = rsp_q.size();
        if (pend > max_pend) max_pend = pend;
        if (pend >= TB_MAX && mem_if.mem_req === 1'b1) lim_viol++;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata  = '0;
        if (rsp_q.size() != 0 && rsp_q[0].due <= edge_no) begin
            mem_if.mem_rvalid = 1'b1;
            mem_if.mem_rdata  = rsp_q[0].addr[15:0];
            void'(rsp_q.pop_front());
            n_resp++;
        end
        mem_if.mem_gnt = gnt_en;
        if (mem_if.mem_req === 1'b1 && gnt_en) begin
            if (n_grant == 0) first_addr = mem_if.mem_addr;
            else if (mem_if.mem_addr !== last_addr + 17'd1) bad_seq++;
            last_addr = mem_if.mem_addr;
            n_grant++;
            rsp_q.push_back('{mem_if.mem_addr, edge_no + lat});
        end
        edge_no++;
    endtask

    task automatic tick(input logic [15:0] want);
        p_rgb[1] = p_rgb[0];
        p_de[1]  = p_de[0];
        p_hs[1]  = p_hs[0];
        p_vs[1]  = p_vs[0];
        p_rgb[0] = display_en ? want : 16'h0;
        p_de[0]  = display_en;
        p_hs[0]  = hsync_in;
        p_vs[0]  = vsync_in;
        mem_step();
        @(posedge clk);
        @(negedge clk);
        if (chk_en) begin
            check("rgb",       32'(rgb),       32'(p_rgb[1]));
            check("out_de",    32'(out_de),    32'(p_de[1]));
            check("out_hsync", 32'(out_hsync), 32'(p_hs[1]));
            check("out_vsync", 32'(out_vsync), 32'(p_vs[1]));
        end
    endtask

    task automatic cyc(input logic de, input logic hs, input logic vs, input logic fs,
                       input int x, input int y, input logic [15:0] want);
        display_en  = de;
        hsync_in    = hs;
        vsync_in    = vs;
        frame_start = fs;
        pixel_x     = 10'(x);
        pixel_y     = 10'(y);
        tick(want);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 16'h0);
    endtask

    task automatic row(input int y, input bit expect_ur);
        for (int x = 0; x < 640; x++) cyc(1'b1, 1'b1, 1'b1, 1'b0, x, y, expect_ur ? UC : pix(x, y));
        for (int b = 0; b < 160; b++) cyc(1'b0, (b < 16 || b >= 112), 1'b1, 1'b0, 0, 0, 16'h0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},   32'(mem_if.mem_req), 32'd0);
        check({tag, "_addr"},  32'(mem_if.mem_addr), 32'd0);
        check({tag, "_rgb"},   32'(rgb),       32'd0);
        check({tag, "_de"},    32'(out_de),    32'd0);
        check({tag, "_hs"},    32'(out_hsync), 32'd1);
        check({tag, "_vs"},    32'(out_vsync), 32'd1);
        check({tag, "_ur"},    32'(underrun),  32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        display_en  = 1'b0;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        frame_start = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        mem_if.mem_gnt    = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata  = '0;
        for (int i = 0; i < 2; i++) begin
            p_rgb[i] = '0; p_de[i] = 1'b0; p_hs[i] = 1'b1; p_vs[i] = 1'b1;
        end
        clear_log();
        @(negedge clk);

        idle(3);
        chk_en = 1'b1;
        check_reset_values("por");
        rst_n = 1'b1;
        idle(4);

        // Reset in the middle of a fetch.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 16'h0);
        idle(30);
        check("midfetch_req", 32'(mem_if.mem_req), 32'd1);
        rst_n = 1'b0;
        idle(3);
        check_reset_values("rst");
        rst_n = 1'b1;
        idle(10);

        // Line 0 fetch stream, then four 2x-scaled rows.
        clear_log();
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 16'h0);
        check("req_idle", 32'(mem_if.mem_req), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 16'h0);
        check("req_start", 32'(mem_if.mem_req), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 16'h0);
        for (int i = 0; i < 2000 && n_grant < 320; i++) idle(1);
        check("req_drop",   32'(mem_if.mem_req), 32'd0);
        check("grant_cnt",  32'(n_grant), 32'd320);
        check("first_addr", 32'(first_addr), 32'(TB_BASE));
        check("last_addr",  32'(last_addr), 32'(TB_BASE + 17'd319));
        check("addr_seq",   32'(bad_seq), 32'd0);
        idle(100);
        check("resp_cnt",   32'(n_resp), 32'd320);
        for (int y = 0; y < 4; y++) row(y, 1'b0);
        check("ur_clean",   32'(underrun), 32'd0);

        // Outstanding limit with long response latency.
        lat = 10;
        clear_log();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 16'h0);
        for (int i = 0; i < 3000 && n_resp < 320; i++) idle(1);
        check("lim_resp",   32'(n_resp), 32'd320);
        check("lim_grant",  32'(n_grant), 32'd320);
        check("lim_max",    32'(max_pend), 32'(TB_MAX));
        check("lim_viol",   32'(lim_viol), 32'd0);
        check("lim_seq",    32'(bad_seq), 32'd0);
        idle(5);

        // Grants withheld after row 0: row 2 must show the underrun colour.
        lat = 2;
        clear_log();
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 16'h0);
        idle(400);
        check("ur_line0",   32'(n_resp), 32'd320);
        gnt_en = 1'b0;
        row(0, 1'b0);
        row(1, 1'b0);
        check("ur_before",  32'(underrun), 32'd0);
        row(2, 1'b1);
        check("ur_set",     32'(underrun), 32'd1);
        idle(20);
        check("ur_sticky",  32'(underrun), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 16'h0);
        check("ur_cleared", 32'(underrun), 32'd0);
        gnt_en = 1'b1;
        idle(800);

        // Second trigger during ISSUE is dropped.
        clear_log();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 16'h0);
        idle(40);
        check("ov_pre_ur",  32'(underrun), 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, pix(0, 0));
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 16'h0);
        idle(2);
        check("ov_ur",      32'(underrun), 32'd1);
        for (int i = 0; i < 2000 && n_resp < 320; i++) idle(1);
        idle(50);
        check("ov_grant",   32'(n_grant), 32'd320);
        check("ov_first",   32'(first_addr), 32'(TB_BASE));
        check("ov_seq",     32'(bad_seq), 32'd0);
        check("ov_req",     32'(mem_if.mem_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_line_scanout.md
# vga_line_scanout

Pixel-fetch and scan-out stage directly downstream of the VGA timing generator. Consumes its 640x480 pixel coordinates, display enable and syncs, fetches a 320x240 RGB565 framebuffer from memory one source line at a time into ping-pong line buffers, and emits 2x-scaled pixels with syncs delayed to match. Also flags memory underrun and fetch overlap.

## Interface
- FB_BASE, 17'h00000: word address of source pixel (0,0); source line s starts at FB_BASE + s*320
- MAX_OUTSTANDING, 4: max accepted-but-unanswered read requests (1..8)
- UNDERRUN_COLOR, 16'hF81F: RGB565 value shown for pixels not yet fetched

Ports:
- clk  in  1  pixel clock, same as the timing generator
- rst_n  in  1  reset, synchronous, active-low
- pixel_x  in  10  visible X (0..639), 0 outside visible area
- pixel_y  in  10  visible Y (0..479), 0 outside visible area
- display_en  in  1  high in visible area
- hsync_in  in  1  horizontal sync, active-low
- vsync_in  in  1  vertical sync, active-low
- frame_start  in  1  one-cycle pulse at start of frame
- mem_req  out  1  read request; held with mem_addr until mem_gnt
- mem_addr  out  17  word address
- mem_gnt  in  1  request accepted this cycle when mem_req & mem_gnt
- mem_rvalid  in  1  read data valid; responses in request order, latency >= 1
- mem_rdata  in  16  RGB565 pixel
- rgb  out  16  output pixel, 0 when out_de low
- out_hsync  out  1  hsync_in delayed 2 cycles
- out_vsync  out  1  vsync_in delayed 2 cycles
- out_de  out  1  display_en delayed 2 cycles
- underrun  out  1  sticky error, cleared by frame_start

## Operation
- Two line buffers B0/B1, 320x16 each, each with a 9-bit fill count (0..320).
- Fetch triggers (sampled on registered previous values):
  - vsync_in 1->0: fetch source line 0 into B0.
  - display_en 1->0 with pixel_y even and pixel_y < 478: fetch source line s+1 = pixel_y/2 + 1 into B[(s+1)&1].
- Fetch FSM: IDLE -> ISSUE on trigger (fill count of target set to 0, issued = received = 0). ISSUE: mem_req high while issued < 320 and outstanding (issued - received) < MAX_OUTSTANDING; mem_addr = FB_BASE + s*320 + issued; issued increments on mem_req & mem_gnt. ISSUE -> DRAIN when issued reaches 320. DRAIN -> IDLE when received reaches 320.
- Each mem_rvalid writes mem_rdata to target buffer at index = received, then increments received and target fill count. mem_rvalid in IDLE is ignored.
- A trigger while not IDLE is dropped: current fetch continues, underrun set.
- Scan-out for each cycle with display_en high:
  - buffer = (pixel_y>>1)&1; index = pixel_x>>1.
  - If index < fill count, output buffer data; else output UNDERRUN_COLOR and set underrun.
- underrun: set-priority over frame_start clear in the same cycle.
- Address arithmetic: 17-bit unsigned, wraps modulo 2^17.

## Timing
- Reset (rst_n low at clk edge): FSM IDLE, counters and fill counts 0, mem_req 0, mem_addr 0, rgb 0, out_de 0, out_hsync 1, out_vsync 1, underrun 0. Reset mid-fetch abandons it. Responses still in flight after reset are ignored.
- Scan-out latency: inputs sampled at edge N appear on rgb/out_* after edge N+2. Syncs and DE use the identical 2-stage delay.
- Line buffer read: registered, 1 cycle. A write at edge N is readable by a lookup sampled at edge N+1 or later.
- Write/read of the same buffer in the same cycle is legal. The read uses the fill count before the increment.
- Fetch start: mem_req asserts the cycle after the trigger edge. With mem_gnt tied high and response latency L, a line completes in 320 + L + 1 cycles.
- Budget: a line fetch must finish within one 800-cycle line period plus blanking; slower memory yields underrun.

## Test plan
- Reset: hold rst_n low 3 cycles mid-fetch -> all outputs at reset values, mem_req 0. Next vsync fall restarts line 0 at address FB_BASE.
- Line 0 fetch, FB_BASE=17'h01000, gnt=1, latency 2: vsync_in falls -> 320 requests at 0x01000..0x0113F, consecutive. mem_req drops after the 320th grant.
- Scaling: memory word = address low 16 bits, full frame. Pixel (x,y) appears on rgb 2 cycles later as FB_BASE + (y/2)*320 + x/2. out_de, out_hsync, out_vsync equal their inputs delayed by 2. rgb is 0 when out_de is 0.
- Outstanding limit: gnt=1, response latency 10, MAX_OUTSTANDING=4 -> never more than 4 unanswered grants. mem_req low while 4 are pending.
- Underrun: mem_gnt held 0 after row 0 end -> row 2 shows UNDERRUN_COLOR and underrun=1. underrun stays high until frame_start, then reads 0.
- Overlap: second trigger issued while in ISSUE -> request stream continues unchanged for the original line, underrun=1.
